oven_key_conditioner: RTL and testbench



---
 rtl/oven_key_if.sv | 30 +++
 rtl/oven_key_conditioner.sv | 155 +++++++++++++++
 tb/tb_oven_key_conditioner.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/oven_key_if.sv
// Key bundle between the raw switch/button pins and the oven controller.
// The conditioner is the slave: it samples key_raw and drives the conditioned outputs.
interface oven_key_if #(
    parameter int N_KEYS = 5
);
    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_repeat;
    logic [N_KEYS-1:0] key_step;

    modport master (
        output key_raw,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_repeat,
        input  key_step
    );

    modport slave (
        input  key_raw,
        output key_level,
        output key_press,
        output key_release,
        output key_repeat,
        output key_step
    );
endinterface

// File: rtl/oven_key_conditioner.sv
// Oven controller input front end: per-lane synchroniser, debouncer, press/release
// pulse generator and auto-repeat engine for the temp/time keys.
module oven_key_conditioner #(
    parameter int                N_KEYS          = 5,
    parameter int                DEBOUNCE_CYCLES = 1_000_000,
    parameter int                REPEAT_DELAY    = 25_000_000,
    parameter int                REPEAT_RATE     = 5_000_000,
    parameter logic [N_KEYS-1:0] REPEAT_MASK     = 5'b11000
) (
    input  logic       clk,
    input  logic       rst,
    oven_key_if.slave  keys
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_DELAY + 1);

    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_INIT = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_INIT  = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_RPT
    } rpt_state_t;

    logic [N_KEYS-1:0] sync_meta;
    logic [N_KEYS-1:0] sync_out;
    logic [N_KEYS-1:0] level_vec;
    logic [N_KEYS-1:0] press_evt;
    logic [N_KEYS-1:0] release_evt;
    logic [N_KEYS-1:0] repeat_evt;

    logic [N_KEYS-1:0] press_r;
    logic [N_KEYS-1:0] release_r;
    logic [N_KEYS-1:0] repeat_r;
    logic [N_KEYS-1:0] step_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= '0;
            sync_out  <= '0;
        end else begin
            sync_meta <= keys.key_raw;
            sync_out  <= sync_meta;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_lane
        logic [DW-1:0] cnt;
        logic          level_q;
        logic          accept;

        // A change is accepted on the cycle the mismatch run reaches DEBOUNCE_CYCLES.
        assign accept         = (sync_out[i] != level_q) && (cnt == DEB_LAST);
        assign press_evt[i]   = accept & sync_out[i];
        assign release_evt[i] = accept & ~sync_out[i];
        assign level_vec[i]   = level_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt     <= '0;
                level_q <= 1'b0;
            end else if (sync_out[i] == level_q) begin
                cnt <= '0;
            end else if (accept) begin
                level_q <= sync_out[i];
                cnt     <= '0;
            end else begin
                cnt <= cnt + DW'(1);
            end
        end

        if (REPEAT_MASK[i]) begin : g_rpt
            rpt_state_t    state;
            rpt_state_t    state_nxt;
            logic [RW-1:0] rcnt;
            logic [RW-1:0] rcnt_nxt;
            logic          rep_nxt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state <= ST_IDLE;
                    rcnt  <= '0;
                end else begin
                    state <= state_nxt;
                    rcnt  <= rcnt_nxt;
                end
            end

            always_comb begin
                state_nxt = state;
                case (state)
                    ST_IDLE: begin
                        if (press_evt[i]) state_nxt = ST_DELAY;
                    end
                    ST_DELAY: begin
                        if (release_evt[i])   state_nxt = ST_IDLE;
                        else if (rcnt == '0)  state_nxt = ST_RPT;
                    end
                    ST_RPT: begin
                        if (release_evt[i]) state_nxt = ST_IDLE;
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end

            // Release wins over an expiring count so nothing repeats on the release edge.
            always_comb begin
                rcnt_nxt = rcnt;
                rep_nxt  = 1'b0;
                case (state)
                    ST_IDLE: begin
                        rcnt_nxt = press_evt[i] ? DELAY_INIT : '0;
                    end
                    ST_DELAY, ST_RPT: begin
                        if (release_evt[i]) begin
                            rcnt_nxt = '0;
                        end else if (rcnt == '0) begin
                            rep_nxt  = 1'b1;
                            rcnt_nxt = RATE_INIT;
                        end else begin
                            rcnt_nxt = rcnt - RW'(1);
                        end
                    end
                    default: rcnt_nxt = '0;
                endcase
            end

            assign repeat_evt[i] = rep_nxt;
        end else begin : g_norpt
            assign repeat_evt[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            press_r   <= '0;
            release_r <= '0;
            repeat_r  <= '0;
            step_r    <= '0;
        end else begin
            press_r   <= press_evt;
            release_r <= release_evt;
            repeat_r  <= repeat_evt;
            step_r    <= press_evt | repeat_evt;
        end
    end

    assign keys.key_level   = level_vec;
    assign keys.key_press   = press_r;
    assign keys.key_release = release_r;
    assign keys.key_repeat  = repeat_r;
    assign keys.key_step    = step_r;
endmodule

// File: tb/tb_oven_key_conditioner.sv
// Scoreboard bench for oven_key_conditioner: a window-based reference model predicts
// every level change and pulse; a negedge monitor pops and compares DUT events.
module tb_oven_key_conditioner;
    localparam int N   = 5;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RR  = 3;
    localparam int HL  = DEB + 2;
    localparam logic [N-1:0] MASK = 5'b11000;

    typedef struct {
        int           cyc;
        logic [N-1:0] level;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] rpt;
        logic [N-1:0] step;
    } exp_t;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t         sb[$];
    logic [N-1:0] hist[$];
    logic [N-1:0] lvl;
    logic [N-1:0] pvalid;
    int           pedge[N];
    logic [N-1:0] mp, mr, mq;
    logic [N-1:0] prev_level;
    exp_t         ent;

    oven_key_if #(.N_KEYS(N)) keys();

    oven_key_conditioner #(
        .N_KEYS(N),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR),
        .REPEAT_MASK(MASK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .keys(keys)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a level flips once the DEB samples seen through the two-stage
    // synchroniser all agree on the opposite value; repeats follow from press age.
    initial begin
        lvl    = '0;
        pvalid = '0;
        for (int i = 0; i < HL; i++) hist.push_back('0);
        for (int i = 0; i < N; i++) pedge[i] = 0;
    end

    always @(posedge clk) begin
        cyc++;
        mp = '0;
        mr = '0;
        mq = '0;
        if (rst) begin
            hist[HL-1] = '0;
            hist.push_back('0);
            void'(hist.pop_front());
            if (lvl != '0) begin
                ent = '{cyc, '0, '0, '0, '0, '0};
                sb.push_back(ent);
            end
            lvl    = '0;
            pvalid = '0;
        end else begin
            hist.push_back(keys.key_raw);
            void'(hist.pop_front());
            for (int i = 0; i < N; i++) begin
                logic v;
                logic stable;
                v      = hist[HL-3][i];
                stable = 1'b1;
                for (int j = 0; j < DEB; j++)
                    if (hist[HL-3-j][i] != v) stable = 1'b0;
                if (stable && v != lvl[i]) begin
                    lvl[i] = v;
                    if (v) begin
                        mp[i]     = 1'b1;
                        pedge[i]  = cyc;
                        pvalid[i] = 1'b1;
                    end else begin
                        mr[i]     = 1'b1;
                        pvalid[i] = 1'b0;
                    end
                end
                if (MASK[i] && lvl[i] && pvalid[i] && !mp[i]) begin
                    int d;
                    d = cyc - pedge[i];
                    if (d >= RD && ((d - RD) % RR) == 0) mq[i] = 1'b1;
                end
            end
            if ((mp | mr | mq) != '0) begin
                ent = '{cyc, lvl, mp, mr, mq, mp | mq};
                sb.push_back(ent);
            end
        end
    end

    task automatic checkField(input string name, input logic [N-1:0] act,
                              input logic [N-1:0] req, input int at);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, at, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (e.cyc != cyc) begin
            errors++;
            $display("[TB] FAIL event_cycle: got event at cycle %0d, expected cycle %0d", cyc, e.cyc);
        end
        checkField("key_level",   keys.key_level,   e.level, e.cyc);
        checkField("key_press",   keys.key_press,   e.press, e.cyc);
        checkField("key_release", keys.key_release, e.rel,   e.cyc);
        checkField("key_repeat",  keys.key_repeat,  e.rpt,   e.cyc);
        checkField("key_step",    keys.key_step,    e.step,  e.cyc);
    endtask

    task automatic checkResetState();
        checkField("rst_level",   keys.key_level,   '0, cyc);
        checkField("rst_press",   keys.key_press,   '0, cyc);
        checkField("rst_release", keys.key_release, '0, cyc);
        checkField("rst_repeat",  keys.key_repeat,  '0, cyc);
        checkField("rst_step",    keys.key_step,    '0, cyc);
    endtask

    // Monitor: every DUT event (pulse or level change) must match the oldest prediction.
    initial prev_level = '0;

    always @(negedge clk) begin
        logic trig;
        trig = ((keys.key_press | keys.key_release | keys.key_repeat | keys.key_step) != '0)
               || (keys.key_level !== prev_level);
        prev_level = keys.key_level;
        if (trig) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_event at cycle %0d: level %b press %b release %b repeat %b step %b, expected none",
                         cyc, keys.key_level, keys.key_press, keys.key_release,
                         keys.key_repeat, keys.key_step);
            end else begin
                checkOutput(sb.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic [N-1:0] raw, input int cycles);
        keys.key_raw = raw;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        keys.key_raw = '0;
        repeat (3) @(negedge clk);
        checkResetState();
        rst = 1'b0;

        $display("[TB] clean press/release on lane A");
        applyStimulus(5'b00001, 20);
        applyStimulus(5'b00000, 20);

        $display("[TB] bouncing lane D");
        for (int k = 0; k < 10; k++) applyStimulus((k % 2) ? 5'b01000 : 5'b00000, 2);
        applyStimulus(5'b00000, 12);
        checkField("bounce_level", keys.key_level, '0, cyc);

        $display("[TB] auto-repeat on lane E");
        applyStimulus(5'b10000, 40);
        applyStimulus(5'b00000, 20);

        $display("[TB] unmasked lane B hold");
        applyStimulus(5'b00010, 40);
        applyStimulus(5'b00000, 20);

        $display("[TB] reset during repeat delay on lane D");
        applyStimulus(5'b01000, 10);
        rst = 1'b1;
        @(posedge clk);
        #1 checkResetState();
        @(negedge clk);
        @(posedge clk);
        #1 checkResetState();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(5'b01000, 30);
        applyStimulus(5'b00000, 20);

        $display("[TB] simultaneous D and E");
        applyStimulus(5'b11000, 40);
        applyStimulus(5'b00000, 20);

        $display("[TB] randomized phase");
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                applyStimulus(5'($urandom_range(0, 31)), $urandom_range(1, 3));
                rst = 1'b0;
            end
            applyStimulus(5'($urandom_range(0, 31)), $urandom_range(1, 14));
        end
        applyStimulus(5'b00000, 30);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_events: %0d predicted events never seen, expected 0", sb.size());
        end
        checkField("final_level", keys.key_level, '0, cyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end
endmodule
